// File: rtl/fdau_pkg.sv
// rtl/fdau_pkg.sv - shared state encoding and frame defaults for the FDAU frame transmitter
package fdau_pkg;

  // Words per FDAU frame; the transmitter default tracks the assembler
  localparam int          FRAME_WORDS_DEF = 260;
  localparam logic [15:0] SYNC_WORD_DEF   = 16'hA55A;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SEND_SYNC = 4'd1,
    SEND_CNT  = 4'd2,
    RD_ADDR   = 4'd3,
    RD_WAIT   = 4'd4,
    RD_LATCH  = 4'd5,
    SEND_HI   = 4'd6,
    SEND_LO   = 4'd7,
    SEND_SUM  = 4'd8,
    DONE      = 4'd9
  } state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 LSB-first byte serializer paced by baud_tick
module uart_byte_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [7:0] byte_in,
  input  logic       byte_load,
  output logic       byte_ready,
  output logic       TX
);

  logic [7:0] r_shift;
  logic [3:0] r_tick;
  logic       r_ready;
  logic       r_tx;

  // Load when idle, then walk start/data/stop one bit per tick; ready returns one tick after stop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= 8'h00;
      r_tick  <= 4'd0;
      r_ready <= 1'b1;
      r_tx    <= 1'b1;
    end else if (r_ready) begin
      if (byte_load) begin
        r_shift <= byte_in;
        r_tick  <= 4'd0;
        r_ready <= 1'b0;
      end
    end else if (baud_tick) begin
      r_tick <= r_tick + 4'd1;
      case (r_tick)
        4'd0: r_tx <= 1'b0;
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b0, r_shift[7:1]};
        end
        4'd9: r_tx <= 1'b1;
        4'd10: begin
          r_ready <= 1'b1;
          r_tick  <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign byte_ready = r_ready;
  assign TX         = r_tx;

endmodule

// File: rtl/fdau_frame_tx.sv
// rtl/fdau_frame_tx.sv - reads one FDAU frame from RAM and sends it framed and checksummed over UART
module fdau_frame_tx
  import fdau_pkg::*;
#(
  parameter int          FRAME_WORDS = FRAME_WORDS_DEF,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sec,
  input  logic        baud_tick,
  output logic [8:0]  rd_fdau,
  input  logic [15:0] q_fdau,
  output logic        TX,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        overrun
);

  localparam logic [8:0] LAST_ADDR = 9'(FRAME_WORDS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_sum;
  logic [15:0] r_word;
  logic [15:0] r_hdr;
  logic [15:0] r_frame_cnt;
  logic [8:0]  r_addr;
  logic        r_lo;
  logic        r_busy;
  logic        r_overrun;
  logic [7:0]  w_byte;
  logic        w_load;
  logic        w_ready;
  logic        w_last;

  assign w_last = (r_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and serializer hand-off; each send state offers a byte only while the serializer is ready
  always_comb begin
    w_next = r_state;
    w_byte = 8'h00;
    w_load = 1'b0;
    case (r_state)
      IDLE: if (sec) w_next = SEND_SYNC;
      SEND_SYNC: begin
        w_byte = r_lo ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
        w_load = w_ready;
        if (w_ready && r_lo) w_next = SEND_CNT;
      end
      SEND_CNT: begin
        w_byte = r_lo ? r_hdr[7:0] : r_hdr[15:8];
        w_load = w_ready;
        if (w_ready && r_lo) w_next = RD_ADDR;
      end
      RD_ADDR:  w_next = RD_WAIT;
      RD_WAIT:  w_next = RD_LATCH;
      RD_LATCH: w_next = SEND_HI;
      SEND_HI: begin
        w_byte = r_word[15:8];
        w_load = w_ready;
        if (w_ready) w_next = SEND_LO;
      end
      SEND_LO: begin
        w_byte = r_word[7:0];
        w_load = w_ready;
        if (w_ready) w_next = w_last ? SEND_SUM : RD_ADDR;
      end
      SEND_SUM: begin
        w_byte = r_lo ? r_sum[7:0] : r_sum[15:8];
        w_load = w_ready;
        if (w_ready && r_lo) w_next = DONE;
      end
      DONE: if (w_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame datapath: header capture, address walk, checksum, busy and overrun flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sum       <= 16'h0000;
      r_word      <= 16'h0000;
      r_hdr       <= 16'h0000;
      r_frame_cnt <= 16'h0000;
      r_addr      <= 9'd0;
      r_lo        <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // A strobe arriving in any busy cycle, including the one that ends the frame, is dropped
      if (sec && r_busy) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (sec) begin
          r_busy      <= 1'b1;
          r_sum       <= 16'h0000;
          r_addr      <= 9'd0;
          r_lo        <= 1'b0;
          r_hdr       <= r_frame_cnt;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
        SEND_SYNC, SEND_CNT, SEND_SUM: if (w_ready) r_lo <= ~r_lo;
        RD_LATCH: begin
          r_word <= q_fdau;
          r_sum  <= r_sum + q_fdau;
        end
        // The address parks on the last word instead of stepping past it, so a 512-word
        // frame cannot wrap the 9-bit address back to 0
        SEND_LO: if (w_ready && !w_last) r_addr <= r_addr + 9'd1;
        DONE: if (w_ready) r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  uart_byte_tx u_ser (
    .clock      (clock),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .byte_in    (w_byte),
    .byte_load  (w_load),
    .byte_ready (w_ready),
    .TX         (TX)
  );

  assign rd_fdau   = r_addr;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_overrun;

endmodule
